// File: rtl/shift_sequencer.sv
// shift_sequencer: multicycle shifter; moves the operand one bit per clock
// under a start/busy/done handshake, holding the result until the next start.
module shift_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] in_value,
   input  logic [31:0] in_amount,
   output logic [31:0] out,
   output logic        busy,
   output logic        done
);
   localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2;
   logic [1:0] state, opQ;
   logic [4:0] count;
   logic [31:0] stepped;
   logic unusedAmount;
   assign unusedAmount = ^in_amount[31:5];
   always_comb
      stepped = opQ == 2'b00 ? {out[30:0], 1'b0} :
                opQ == 2'b01 ? {1'b0, out[31:1]} :
                opQ == 2'b10 ? {out[31], out[31:1]} : {out[0], out[31:1]};
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         out   <= '0;
         count <= '0;
         opQ   <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               out   <= in_value;
               opQ   <= op;
               count <= in_amount[4:0];
               state <= in_amount[4:0] != 5'd0 ? SHIFT : DONE;
            end
            SHIFT: begin
               out   <= stepped;
               count <= count - 5'd1;
               if (count == 5'd1) state <= DONE;
            end
            default: state <= IDLE;
         endcase
      end
   end
   assign busy = state == SHIFT || state == DONE;
   assign done = state == DONE;
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed vectors with hand-computed results for shift_sequencer.
module tb_shift_sequencer;
   logic clk = 0, reset = 1, start = 0, busy, done;
   logic [1:0] op = 0;
   logic [31:0] inValue = 0, inAmount = 0, out;
   int nChecks = 0, nFails = 0;
   shift_sequencer dut (.clk(clk), .reset(reset), .start(start), .op(op), .in_value(inValue),
                        .in_amount(inAmount), .out(out), .busy(busy), .done(done));
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) begin
         nFails++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   // Waits for done (bounded); returns edges after E0 and busy cycles seen.
   task automatic waitDone(output int lat, output int busyCycles);
      lat = 0;
      busyCycles = busy ? 1 : 0;
      while (!done && lat < 40) begin
         tick();
         lat++;
         if (busy) busyCycles++;
      end
   endtask
   task automatic runOp(input string tag, input logic [31:0] v, input logic [31:0] a,
                        input logic [1:0] o, input logic [31:0] expOut, input int expLat,
                        input int expBusy);
      int lat, bc;
      inValue = v; inAmount = a; op = o; start = 1;
      tick();
      start = 0; inValue = 32'h5A5A_5A5A; inAmount = 32'd7; op = ~o;
      waitDone(lat, bc);
      check({tag, "_lat"}, lat, expLat);
      check({tag, "_busy"}, bc, expBusy);
      check({tag, "_out"}, out, expOut);
      tick();
      check({tag, "_donePulse"}, {busy, done}, 2'b00);
      check({tag, "_held"}, out, expOut);
   endtask
   initial begin
      int lat, bc, pulses;
      tick(); tick();
      reset = 0;
      check("reset_out", out, 32'h0);
      check("reset_flags", {busy, done}, 2'b00);
      runOp("sll4", 32'h0000_0001, 32'd4, 2'b00, 32'h0000_0010, 4, 5);
      runOp("sra3", 32'h8000_0000, 32'h0000_0023, 2'b10, 32'hF000_0000, 3, 4);
      runOp("srl3", 32'h8000_0000, 32'h0000_0023, 2'b01, 32'h1000_0000, 3, 4);
      runOp("ror1", 32'h0000_0001, 32'd1, 2'b11, 32'h8000_0000, 1, 2);
      runOp("zero", 32'hDEAD_BEEF, 32'd0, 2'b11, 32'hDEAD_BEEF, 0, 1);
      runOp("max31", 32'hFFFF_FFFF, 32'd31, 2'b00, 32'h8000_0000, 31, 32);
      runOp("mod33", 32'h0000_0003, 32'd33, 2'b11, 32'h8000_0001, 1, 2);
      runOp("sraPos", 32'h7000_0000, 32'd4, 2'b10, 32'h0700_0000, 4, 5);
      // start pulse during SHIFT must be ignored
      inValue = 32'h1; inAmount = 32'd5; op = 2'b00; start = 1;
      tick();
      start = 0;
      tick(); tick();
      inValue = 32'hFFFF_FFFF; inAmount = 32'd2; start = 1;
      tick();
      start = 0;
      waitDone(lat, bc);
      check("ign_lat", lat + 3, 5);
      check("ign_out", out, 32'h0000_0020);
      tick();
      // start held: next op accepted only at the first IDLE edge
      inValue = 32'h1; inAmount = 32'd5; op = 2'b00; start = 1;
      tick();
      inValue = 32'h3; inAmount = 32'd1;
      waitDone(lat, bc);
      check("held_lat", lat, 5);
      check("held_out", out, 32'h0000_0020);
      tick();
      check("held_idle", {busy, done}, 2'b00);
      check("held_idleOut", out, 32'h0000_0020);
      tick();
      start = 0;
      check("held_accept", {busy, done}, 2'b10);
      check("held_acceptOut", out, 32'h3);
      tick();
      check("held_second", {out[3:0], busy, done}, 6'b0110_11);
      tick();
      // reset at E2 of a 10-step shift aborts without a done pulse
      inValue = 32'h1; inAmount = 32'd10; op = 2'b00; start = 1;
      tick();
      start = 0;
      tick();
      reset = 1;
      tick();
      reset = 0;
      check("rst_out", out, 32'h0);
      check("rst_flags", {busy, done}, 2'b00);
      pulses = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (done || busy) pulses++;
      end
      check("rst_noDone", pulses, 0);
      // reset wins over start
      runOp("pre", 32'h0000_0001, 32'd2, 2'b00, 32'h0000_0004, 2, 3);
      reset = 1; start = 1; inValue = 32'hABCD_0123; inAmount = 32'd0;
      tick();
      reset = 0; start = 0;
      check("rstWins_out", out, 32'h0);
      check("rstWins_flags", {busy, done}, 2'b00);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end
endmodule
